// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: issues single-outstanding bus fetches and buffers
// returned words with their addresses in a small FIFO for the decoder.
module ifu_prefetch #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       req_o,
  output logic [ADDR_W-1:0]          addr_o,
  input  logic                       gnt_i,
  input  logic                       rvalid_i,
  input  logic [DATA_W-1:0]          rdata_i,
  output logic                       inst_valid_o,
  output logic [DATA_W-1:0]          inst_o,
  output logic [ADDR_W-1:0]          inst_addr_o,
  input  logic                       inst_ready_i,
  input  logic                       flush_i,
  input  logic [ADDR_W-1:0]          flush_addr_i,
  input  logic                       halt_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int                PTR_W      = $clog2(DEPTH);
  localparam int                CNT_W      = PTR_W + 1;
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(DATA_W / 8);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(DATA_W / 8 - 1));
  localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pend_addr;
  logic              outstanding;
  logic              discard;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic              grant;
  logic              resp;
  logic              push;
  logic              pop;

  // A request needs a free slot for its eventual response; the discard flag keeps
  // outstanding set so a stale response can never race a fresh request.
  always_comb begin
    req_o        = rst && !outstanding && (count < DEPTH_C) && !halt_i && !flush_i;
    addr_o       = pc;
    grant        = req_o && gnt_i;
    resp         = rvalid_i && outstanding;
    push         = resp && !discard && !flush_i;
    inst_valid_o = (count != '0);
    pop          = inst_valid_o && inst_ready_i && !flush_i;
    inst_o       = inst_valid_o ? data_mem[head] : '0;
    inst_addr_o  = inst_valid_o ? addr_mem[head] : '0;
    count_o      = count;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      pend_addr   <= '0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
    end else begin
      if (flush_i) begin
        pc <= flush_addr_i & ALIGN_MASK;
      end else if (grant) begin
        pc <= pc + STEP;
      end
      if (grant) begin
        outstanding <= 1'b1;
        pend_addr   <= pc;
      end else if (resp) begin
        outstanding <= 1'b0;
        discard     <= 1'b0;
      end
      if (flush_i && outstanding && !rvalid_i) begin
        discard <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: reads are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[tail] <= rdata_i;
      addr_mem[tail] <= pend_addr;
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: directed scenarios plus randomized bus/consumer traffic,
// all checked against a queue-based model of the fetch/buffer rules.
module tb_ifu_prefetch;

  localparam int          ADDR_W   = 32;
  localparam int          DATA_W   = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_o;
  logic [ADDR_W-1:0] addr_o;
  logic              gnt_i;
  logic              rvalid_i;
  logic [DATA_W-1:0] rdata_i;
  logic              inst_valid_o;
  logic [DATA_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_addr_o;
  logic              inst_ready_i;
  logic              flush_i;
  logic [ADDR_W-1:0] flush_addr_i;
  logic              halt_i;
  logic [2:0]        count_o;

  always #5 clk = ~clk;

  ifu_prefetch #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst), .req_o(req_o), .addr_o(addr_o), .gnt_i(gnt_i),
    .rvalid_i(rvalid_i), .rdata_i(rdata_i), .inst_valid_o(inst_valid_o),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .inst_ready_i(inst_ready_i),
    .flush_i(flush_i), .flush_addr_i(flush_addr_i), .halt_i(halt_i), .count_o(count_o)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  int          checks = 0;
  int          errors = 0;
  entry_t      q[$];
  logic [31:0] m_pc;
  logic [31:0] m_pend_addr;
  bit          m_pend;
  bit          m_stale;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_req();
    return rst && !m_pend && (q.size() < DEPTH) && !halt_i && !flush_i;
  endfunction

  function automatic bit free_to_grant(input bit hlt, input bit fl);
    return !m_pend && (q.size() < DEPTH) && !hlt && !fl;
  endfunction

  // Drive one cycle's inputs, then compare every output against the model.
  task automatic apply_stimulus(input bit gnt, input bit rv, input bit rdy, input bit fl,
                                input logic [31:0] faddr, input bit hlt);
    bit exp_req;
    gnt_i        = gnt;
    rvalid_i     = rv;
    rdata_i      = $urandom;
    inst_ready_i = rdy;
    flush_i      = fl;
    flush_addr_i = faddr;
    halt_i       = hlt;
    #3;
    exp_req = model_req();
    check_output("req_o", {63'd0, req_o}, {63'd0, exp_req});
    if (exp_req) check_output("addr_o", {32'd0, addr_o}, {32'd0, m_pc});
    check_output("count_o", {61'd0, count_o}, 64'(q.size()));
    check_output("count_bound", {63'd0, (count_o <= 3'(DEPTH))}, 64'd1);
    check_output("inst_valid_o", {63'd0, inst_valid_o}, {63'd0, (q.size() != 0)});
    if (q.size() != 0) begin
      check_output("inst_o", {32'd0, inst_o}, {32'd0, q[0].data});
      check_output("inst_addr_o", {32'd0, inst_addr_o}, {32'd0, q[0].addr});
    end else begin
      check_output("inst_o_empty", {32'd0, inst_o}, 64'd0);
      check_output("inst_addr_o_empty", {32'd0, inst_addr_o}, 64'd0);
    end
  endtask

  // Apply the effect of the coming rising edge to the model, then advance to it.
  task automatic tick();
    bit     req;
    bit     grant;
    bit     resp;
    bit     was_pend;
    entry_t e;
    req      = model_req();
    grant    = req && gnt_i;
    was_pend = m_pend;
    resp     = rvalid_i && was_pend;
    if (flush_i) begin
      q.delete();
    end else begin
      if (q.size() != 0 && inst_ready_i) void'(q.pop_front());
      if (resp && !m_stale) begin
        e.addr = m_pend_addr;
        e.data = rdata_i;
        q.push_back(e);
      end
    end
    if (grant) begin
      m_pend      = 1'b1;
      m_stale     = 1'b0;
      m_pend_addr = m_pc;
    end else if (resp) begin
      m_pend  = 1'b0;
      m_stale = 1'b0;
    end
    if (flush_i && was_pend && !rvalid_i) m_stale = 1'b1;
    if (flush_i) m_pc = flush_addr_i & 32'hFFFF_FFFC;
    else if (grant) m_pc = m_pc + 32'd4;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit gnt, input bit rv, input bit rdy, input bit fl,
                      input logic [31:0] faddr, input bit hlt);
    apply_stimulus(gnt, rv, rdy, fl, faddr, hlt);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0; inst_ready_i = 1'b0;
    flush_i = 1'b0; flush_addr_i = '0; halt_i = 1'b0;
    #1;
    check_output("rst_req_o", {63'd0, req_o}, 64'd0);
    check_output("rst_addr_o", {32'd0, addr_o}, {32'd0, RESET_PC});
    check_output("rst_count_o", {61'd0, count_o}, 64'd0);
    check_output("rst_inst_valid_o", {63'd0, inst_valid_o}, 64'd0);
    check_output("rst_inst_o", {32'd0, inst_o}, 64'd0);
    check_output("rst_inst_addr_o", {32'd0, inst_addr_o}, 64'd0);
    q.delete();
    m_pc = RESET_PC; m_pend = 1'b0; m_stale = 1'b0; m_pend_addr = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_output("post_rst_req_o", {63'd0, req_o}, 64'd1);
    check_output("post_rst_addr_o", {32'd0, addr_o}, {32'd0, RESET_PC});
  endtask

  // Bus grants only what is requested and answers only what is outstanding.
  task automatic run_auto(input int n, input int pg, input int pr, input int prdy,
                          input int ph, input int pf);
    bit hlt, fl, g, rv, rdy;
    for (int i = 0; i < n; i++) begin
      hlt = ($urandom_range(99) < ph);
      fl  = ($urandom_range(99) < pf);
      g   = free_to_grant(hlt, fl) && ($urandom_range(99) < pg);
      rv  = m_pend && ($urandom_range(99) < pr);
      rdy = ($urandom_range(99) < prdy);
      step(g, rv, rdy, fl, $urandom, hlt);
    end
  endtask

  initial begin
    bit exp_v;
    $display("[TB] ifu_prefetch bench start");
    do_reset();

    // Streaming: one instruction every two cycles, heads at 0x0, 0x4, 0x8.
    for (int c = 0; c < 8; c++) begin
      apply_stimulus(free_to_grant(1'b0, 1'b0), m_pend, 1'b1, 1'b0, '0, 1'b0);
      exp_v = (c >= 2) && (c % 2 == 0);
      check_output("stream_valid", {63'd0, inst_valid_o}, {63'd0, exp_v});
      if (exp_v) check_output("stream_head", {32'd0, inst_addr_o}, 64'((c / 2 - 1) * 4));
      tick();
    end

    // Fill: FIFO reaches DEPTH, requests stop, one pop re-opens fetch at 0x10.
    do_reset();
    run_auto(9, 100, 100, 0, 0, 0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    check_output("fill_count", {61'd0, count_o}, 64'd4);
    check_output("fill_req", {63'd0, req_o}, 64'd0);
    tick();
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    check_output("fill_resume_req", {63'd0, req_o}, 64'd1);
    check_output("fill_resume_addr", {32'd0, addr_o}, 64'h10);
    tick();

    // Flush with a response outstanding for 0x8: stale word dropped, refetch at 0x100.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    check_output("flush_pre_addr", {32'd0, addr_o}, 64'h8);
    tick();
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h103, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    check_output("flush_stale_req", {63'd0, req_o}, 64'd0);
    tick();
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    check_output("flush_count", {61'd0, count_o}, 64'd0);
    check_output("flush_req_addr", {32'd0, addr_o}, 64'h100);
    tick();
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    check_output("flush_head_addr", {32'd0, inst_addr_o}, 64'h100);
    tick();

    // Flush in the same cycle as rvalid: no push, immediate request to the target.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    check_output("flushrv_count", {61'd0, count_o}, 64'd0);
    check_output("flushrv_req", {63'd0, req_o}, 64'd1);
    check_output("flushrv_addr", {32'd0, addr_o}, 64'h200);
    tick();

    // Halt while outstanding: response still lands, fetch resumes at 0x4.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      apply_stimulus(1'b0, (c == 0), 1'b0, 1'b0, '0, 1'b1);
      check_output("halt_req", {63'd0, req_o}, 64'd0);
      tick();
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    check_output("halt_count", {61'd0, count_o}, 64'd1);
    check_output("halt_resume_req", {63'd0, req_o}, 64'd1);
    check_output("halt_resume_addr", {32'd0, addr_o}, 64'h4);
    tick();

    // Address wrap: unaligned redirect near the top of the space, then wrap to 0.
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    check_output("wrap_top_addr", {32'd0, addr_o}, 64'hFFFF_FFFC);
    tick();
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    check_output("wrap_zero_addr", {32'd0, addr_o}, 64'h0);
    tick();
    run_auto(6, 100, 100, 100, 0, 0);

    // Reset mid-stream with three entries buffered.
    do_reset();
    run_auto(6, 100, 100, 0, 0, 0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    check_output("midrst_count", {61'd0, count_o}, 64'd3);
    do_reset();

    // Randomized traffic with stalls, halts and redirects.
    run_auto(400, 70, 60, 50, 10, 4);
    run_auto(300, 90, 90, 20, 0, 8);
    run_auto(300, 50, 40, 90, 20, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifu_prefetch.md
IFU_PREFETCH -- requirements
Module: ifu_prefetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning fetch address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning instruction word width; legal values are 32 or 64.
REQ-003 SHALL have parameter DEPTH, default 4, meaning FIFO entries; legal values are powers of two, 2..16.
REQ-004 SHALL have parameter RESET_PC, default 0, meaning first fetch address after reset.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  clock, all state updates on rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous active-low reset.
REQ-007 SHALL have port req_o  out  1  bus fetch request.
REQ-008 SHALL have port addr_o  out  ADDR_W  fetch address, valid while req_o=1.
REQ-009 SHALL have port gnt_i  in  1  bus accepts the request in the cycle req_o&gnt_i.
REQ-010 SHALL have port rvalid_i  in  1  read data returned for the accepted request.
REQ-011 SHALL have port rdata_i  in  DATA_W  returned instruction word.
REQ-012 SHALL have port inst_valid_o  out  1  FIFO head is valid.
REQ-013 SHALL have port inst_o  out  DATA_W  head instruction.
REQ-014 SHALL have port inst_addr_o  out  ADDR_W  head instruction address.
REQ-015 SHALL have port inst_ready_i  in  1  decode consumes the head.
REQ-016 SHALL have port flush_i  in  1  jump or interrupt redirect.
REQ-017 SHALL have port flush_addr_i  in  ADDR_W  redirect target.
REQ-018 SHALL have port halt_i  in  1  debug halt; blocks new requests.
REQ-019 SHALL have port count_o  out  clog2(DEPTH)+1  number of FIFO entries.

Function
REQ-020 SHALL allow at most one outstanding bus request, where outstanding means granted and no rvalid_i received yet.
REQ-021 SHALL assert req_o only when all of the following hold: no request is outstanding, count_o+1 <= DEPTH, halt_i=0, and flush_i=0.
REQ-022 SHALL hold req_o and addr_o stable until gnt_i is asserted.
REQ-023 SHALL advance the fetch PC by DATA_W/8 on each grant, with ADDR_W-bit wrap-around (for example, from all-ones minus 3 to 0 when DATA_W=32).
REQ-024 SHALL write {fetch address, rdata_i} into the tail entry on rvalid_i, unless the response is being discarded.
REQ-025 SHALL make a written entry visible on inst_valid_o in the next cycle, giving a minimum grant-to-head latency of 2 cycles when rvalid_i arrives one cycle after grant.
REQ-026 SHALL pop the head on inst_valid_o & inst_ready_i.
REQ-027 SHALL perform both push and pop when they occur in the same cycle, leaving count unchanged.
REQ-028 SHALL drive inst_o and inst_addr_o to 0 when the FIFO is empty.
REQ-029 SHALL never overflow, because of the credit rule in REQ-021; a push with count=DEPTH is an assertion failure.
REQ-030 SHALL handle the flush_i cycle as follows: FIFO cleared (count 0 next cycle), pop ignored, fetch PC := flush_addr_i with its low clog2(DATA_W/8) bits forced to 0, and req_o=0.
REQ-031 SHALL set a discard flag when flush_i occurs with a request outstanding and no rvalid_i in that cycle; the next rvalid_i is then dropped and the flag cleared.
REQ-032 SHALL drop an rvalid_i that arrives in the same cycle as flush_i.
REQ-033 SHALL treat an outstanding request as still outstanding while the discard flag is set, so no new request is issued until the stale response returns.
REQ-034 SHALL, on a flush while a request is pending but not granted, withdraw req_o in the flush cycle and re-issue it to the new address in the next cycle.
REQ-035 SHALL, under halt_i, block new requests only; an outstanding response still pushes and the consumer may still pop.
REQ-036 SHALL leave all state unchanged when gnt_i and rvalid_i arrive with req_o=0 and nothing outstanding; a bench assertion flags this case.

Reset
REQ-037 SHALL, while rst=0, asynchronously force: req_o=0, addr_o=RESET_PC, fetch PC=RESET_PC, count_o=0, inst_valid_o=0, inst_o=0, inst_addr_o=0, outstanding=0, discard=0.
REQ-038 SHALL assert req_o with addr_o=RESET_PC in the first cycle after rst deasserts, provided halt_i=0.
REQ-039 SHALL, on reset asserted mid-transaction, lose the outstanding request; the bus is reset together with this block.

Verification
REQ-040 SHALL be verified for streaming: gnt immediate, rvalid 1 cycle later, ready=1 -> heads 0x0,0x4,0x8 with rdata matching, one instruction every 2 cycles.
REQ-041 SHALL be verified for fill: DEPTH=4, ready=0 -> count reaches 4, req_o stays 0; one pop -> req_o asserts next cycle at 0x10.
REQ-042 SHALL be verified for flush with outstanding: grant 0x8, flush to 0x103 before rvalid -> stale word dropped, count_o=0, next request at 0x100, head addr 0x100.
REQ-043 SHALL be verified for flush with simultaneous rvalid: rvalid and flush in the same cycle -> no push; next cycle req_o=1 with addr_o=flush target.
REQ-044 SHALL be verified for halt: halt_i=1 while outstanding -> response pushed, no further req_o; release -> fetch resumes at the next sequential PC.
REQ-045 SHALL be verified for reset mid-stream: rst low with count=3 -> all outputs reach reset values immediately; after release, addr_o=RESET_PC.
